counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_if.sv | 15 +
 rtl/counter.sv | 77 +++++++
 tb/tb_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/counter_if.sv
// Bus bundle for the counter: increment/write controls in, count and wrap pulse out.
interface counter_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned WR_W = 32
);
  logic            enable;
  logic            wr_lo;
  logic            wr_hi;
  logic [WR_W-1:0] wr_data;
  logic [XLEN-1:0] out;
  logic            ovf;

  modport master (output enable, wr_lo, wr_hi, wr_data, input out, ovf);
  modport slave  (input enable, wr_lo, wr_hi, wr_data, output out, ovf);
endinterface

// File: rtl/counter.sv
// Free-running XLEN-bit counter with per-half 32-bit load.
// Define COUNTER_OVF_EN to build the registered wrap-around (ovf) detector.
module counter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned WR_W = 32
) (
  input  logic     clk,
  input  logic     resetn,
  counter_if.slave bus
);
  localparam int unsigned HALF = 32;

  logic [XLEN-1:0] out_q, out_d;
  logic [HALF-1:0] wr_half;
  logic            wr_hi_eff;

  assign wr_half   = HALF'(bus.wr_data);
  assign wr_hi_eff = (XLEN == 64) && bus.wr_hi;

  if (XLEN == 64) begin : g_x64
    // A high-half write still lets the low half count, but its carry is dropped.
    always_comb begin
      out_d = out_q;
      if (bus.wr_lo && bus.wr_hi) begin
        out_d = {wr_half, wr_half};
      end else if (bus.wr_lo) begin
        out_d = {out_q[XLEN-1:HALF], wr_half};
      end else if (bus.wr_hi) begin
        out_d = {wr_half, bus.enable ? out_q[HALF-1:0] + HALF'(1) : out_q[HALF-1:0]};
      end else if (bus.enable) begin
        out_d = out_q + XLEN'(1);
      end
    end
  end else if (XLEN == 32) begin : g_x32
    always_comb begin
      out_d = out_q;
      if (bus.wr_lo) begin
        out_d = XLEN'(wr_half);
      end else if (bus.enable) begin
        out_d = out_q + XLEN'(1);
      end
    end
  end else begin : g_bad_xlen
    $error("counter: XLEN must be 32 or 64");
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

`ifdef COUNTER_OVF_EN
  logic ovf_q, ovf_d;

  // Only a pure increment from all-ones is a wrap; writes never are.
  always_comb begin
    ovf_d = bus.enable && !bus.wr_lo && !wr_hi_eff && (out_q == '1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_counter.sv
// Directed self-checking bench for counter (XLEN=64, WR_W=32).
module tb_counter;
  logic clk;
  logic resetn;
  int unsigned errors = 0;
  int unsigned checks = 0;

`ifdef COUNTER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  counter_if #(.XLEN(64), .WR_W(32)) ifc ();

  counter #(.XLEN(64), .WR_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic lo, input logic hi, input logic [31:0] d);
    ifc.enable  = en;
    ifc.wr_lo   = lo;
    ifc.wr_hi   = hi;
    ifc.wr_data = d;
  endtask

  initial begin
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    // Reset asserted with an enable and a write pending: reset must win.
    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h5);
    #1;
    check("reset_out", ifc.out, 64'h0);
    check("reset_ovf", 64'(ifc.ovf), 64'h0);
    tick();
    check("reset_overrides_write", ifc.out, 64'h0);
    tick();
    check("reset_hold", ifc.out, 64'h0);

    resetn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("count_after_reset", ifc.out, 64'(i));
    end

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_disabled", ifc.out, 64'h5);
    end
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_between_edges", ifc.out, 64'h0);
    tick();
    check("async_reset_held", ifc.out, 64'h0);
    resetn = 1'b1;

    drive(1'b0, 1'b1, 1'b0, 32'h10);
    tick();
    check("load_lo_0x10", ifc.out, 64'h10);
    drive(1'b1, 1'b1, 1'b0, 32'hABCD);
    tick();
    check("wr_lo_beats_enable", ifc.out, 64'h0000_0000_0000_ABCD);
    check("wr_lo_no_ovf", 64'(ifc.ovf), 64'h0);

    drive(1'b0, 1'b1, 1'b0, 32'h5);
    tick();
    check("load_lo_5", ifc.out, 64'h5);
    drive(1'b1, 1'b0, 1'b1, 32'h7);
    tick();
    check("wr_hi_lo_increments", ifc.out, 64'h0000_0007_0000_0006);

    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    check("load_lo_ones", ifc.out, 64'h0000_0007_FFFF_FFFF);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    check("load_hi_zero", ifc.out, 64'h0000_0000_FFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("carry_lo_to_hi", ifc.out, 64'h0000_0001_0000_0000);

    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    tick();
    check("wr_lo_no_inc_no_carry", ifc.out, 64'h0000_0001_FFFF_FFFF);
    drive(1'b1, 1'b0, 1'b1, 32'h3);
    tick();
    check("wr_hi_carry_discarded", ifc.out, 64'h0000_0003_0000_0000);

    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    check("load_both_ones", ifc.out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("write_ones_not_wrap", 64'(ifc.ovf), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap_to_zero", ifc.out, 64'h0);
    check("wrap_ovf_pulse", 64'(ifc.ovf), 64'(OVF_ON));
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("after_wrap_hold", ifc.out, 64'h0);
    check("ovf_one_cycle", 64'(ifc.ovf), 64'h0);

    drive(1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    check("load_both_zero", ifc.out, 64'h0);
    check("write_zero_not_wrap", 64'(ifc.ovf), 64'h0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
